triangle_bbox_scanner: RTL and testbench

- Point generator feeding the point-in-triangle tester.
- Latches three vertices, computes their axis-aligned bounding box, and streams every integer point in that box in raster order (x fastest, then y) over a valid/ready handshake.
- Replaces file-driven point stimulus with on-chip rasterization: the tester consumes the points, this block produces them.
- Reports total points emitted and a one-cycle done pulse.

---
 rtl/triangle_bbox_scanner.sv | 147 ++++++++++++++
 tb/tb_triangle_bbox_scanner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/triangle_bbox_scanner.sv
// Triangle bounding-box scanner: latches three vertices, then streams every
// integer point of their bounding box in raster order over valid/ready.
module triangle_bbox_scanner #(
    parameter int W  = 11,
    parameter int CW = 2*W+1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  p1x,
    input  logic [W-1:0]  p1y,
    input  logic [W-1:0]  p2x,
    input  logic [W-1:0]  p2y,
    input  logic [W-1:0]  p3x,
    input  logic [W-1:0]  p3y,
    output logic [W-1:0]  px,
    output logic [W-1:0]  py,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BBOX,
        S_SCAN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [W-1:0]  r_x1, r_y1, r_x2, r_y2, r_x3, r_y3;
    logic [W-1:0]  r_xmin, r_xmax, r_ymin, r_ymax;
    logic [W-1:0]  r_px, r_py;
    logic [CW-1:0] r_count;

    logic [W-1:0]  w_xmin, w_xmax, w_ymin, w_ymax;
    logic          w_hs, w_x_end, w_y_end, w_accept;

    function automatic logic [W-1:0] min3(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [W-1:0] c
    );
        logic [W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [W-1:0] max3(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [W-1:0] c
    );
        logic [W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    assign w_xmin   = min3(r_x1, r_x2, r_x3);
    assign w_xmax   = max3(r_x1, r_x2, r_x3);
    assign w_ymin   = min3(r_y1, r_y2, r_y3);
    assign w_ymax   = max3(r_y1, r_y2, r_y3);
    assign w_accept = (r_state == S_IDLE) & start;
    assign w_hs     = (r_state == S_SCAN) & out_ready;
    assign w_x_end  = (r_px == r_xmax);
    assign w_y_end  = (r_py == r_ymax);

    assign px    = r_px;
    assign py    = r_py;
    assign count = r_count;

    // State register; reset returns to IDLE at once, which drops out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and status outputs decoded from the current state.
    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_BBOX;
            end
            S_BBOX: w_next = S_SCAN;
            S_SCAN: begin
                out_valid = 1'b1;
                if (w_hs && w_x_end && w_y_end) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Vertex capture; inputs are ignored outside an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x1 <= '0; r_y1 <= '0;
            r_x2 <= '0; r_y2 <= '0;
            r_x3 <= '0; r_y3 <= '0;
        end else if (w_accept) begin
            r_x1 <= p1x; r_y1 <= p1y;
            r_x2 <= p2x; r_y2 <= p2y;
            r_x3 <= p3x; r_y3 <= p3y;
        end
    end

    // Box bounds and raster cursor; the cursor only moves on a handshake
    // and is compared against max before incrementing, so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xmin <= '0; r_xmax <= '0;
            r_ymin <= '0; r_ymax <= '0;
            r_px   <= '0; r_py   <= '0;
        end else if (r_state == S_BBOX) begin
            r_xmin <= w_xmin; r_xmax <= w_xmax;
            r_ymin <= w_ymin; r_ymax <= w_ymax;
            r_px   <= w_xmin; r_py   <= w_ymin;
        end else if (w_hs) begin
            if (!w_x_end) begin
                r_px <= r_px + 1'b1;
            end else if (!w_y_end) begin
                r_px <= r_xmin;
                r_py <= r_py + 1'b1;
            end
        end
    end

    // Accepted-point counter, cleared by a new start and held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_count <= '0;
        else if (w_accept) r_count <= '0;
        else if (w_hs)     r_count <= r_count + 1'b1;
    end

endmodule

// File: tb/tb_triangle_bbox_scanner.sv
// Self-checking bench for triangle_bbox_scanner: table-driven scans with a
// point scoreboard, plus hand sequences for busy-start, reset and held start.
module tb_triangle_bbox_scanner;

    localparam int W  = 11;
    localparam int CW = 2*W+1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  p1x = '0, p1y = '0, p2x = '0, p2y = '0, p3x = '0, p3y = '0;
    logic [W-1:0]  px, py;
    logic          out_valid, out_ready = 1'b0, busy, done;
    logic [CW-1:0] count;

    triangle_bbox_scanner #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
        .px(px), .py(py), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ax, ay, bx, by, cx, cy;
        int mode;
        int exp_n;
        int exp_in;
    } vec_t;

    typedef struct {
        int x;
        int y;
    } pt_t;

    pt_t  sb[$];
    vec_t tbl[7];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint edge_fn(input int ax, ay, bx, by, qx, qy);
        return longint'(bx - ax) * (qy - ay) - longint'(by - ay) * (qx - ax);
    endfunction

    function automatic bit inside_tri(input vec_t v, input int qx, qy);
        longint e0, e1, e2;
        e0 = edge_fn(v.ax, v.ay, v.bx, v.by, qx, qy);
        e1 = edge_fn(v.bx, v.by, v.cx, v.cy, qx, qy);
        e2 = edge_fn(v.cx, v.cy, v.ax, v.ay, qx, qy);
        return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
    endfunction

    task automatic drive_vtx(input vec_t v);
        p1x = v.ax[W-1:0]; p1y = v.ay[W-1:0];
        p2x = v.bx[W-1:0]; p2y = v.by[W-1:0];
        p3x = v.cx[W-1:0]; p3y = v.cy[W-1:0];
    endtask

    // mode 0: always ready, 1: random ready, 2: always ready with start
    // and vertex churn while busy.
    task automatic run_scan(input vec_t v);
        int  xmin, xmax, ymin, ymax, n_in;
        bit  got_done, hold;
        int  hx, hy;
        pt_t e;
        vec_t junk;
        xmin = v.ax < v.bx ? v.ax : v.bx; xmin = v.cx < xmin ? v.cx : xmin;
        xmax = v.ax > v.bx ? v.ax : v.bx; xmax = v.cx > xmax ? v.cx : xmax;
        ymin = v.ay < v.by ? v.ay : v.by; ymin = v.cy < ymin ? v.cy : ymin;
        ymax = v.ay > v.by ? v.ay : v.by; ymax = v.cy > ymax ? v.cy : ymax;
        for (int y = ymin; y <= ymax; y++)
            for (int x = xmin; x <= xmax; x++) begin
                e.x = x; e.y = y;
                sb.push_back(e);
            end
        drive_vtx(v);
        out_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        if (v.mode != 2) start = 1'b0;
        else begin
            junk = '{9, 9, 12, 3, 1, 14, 0, 0, 0};
            drive_vtx(junk);
        end
        chk("busy_after_start", busy, 1);
        chk("valid_in_bbox", out_valid, 0);
        chk("count_cleared", count, 0);
        @(posedge clk); #1;
        chk("valid_latency", out_valid, 1);
        chk("origin_x", px, xmin);
        chk("origin_y", py, ymin);
        n_in = 0; got_done = 0; hold = 0; hx = 0; hy = 0;
        for (int c = 0; c < 4000; c++) begin
            out_ready = (v.mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (hold) begin
                chk("stall_x", px, hx);
                chk("stall_y", py, hy);
            end
            hold = 0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("extra_point", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("point_x", px, e.x);
                    chk("point_y", py, e.y);
                end
                if (inside_tri(v, int'(px), int'(py))) n_in++;
            end else if (out_valid) begin
                hold = 1; hx = px; hy = py;
            end
            @(posedge clk); #1;
            if (done) begin
                got_done = 1;
                break;
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk("done_seen", got_done, 1);
        chk("points_left", sb.size(), 0);
        chk("count_at_done", count, v.exp_n);
        chk("inside_count", n_in, v.exp_in);
        chk("busy_in_done", busy, 1);
        chk("valid_in_done", out_valid, 0);
        sb.delete();
        @(posedge clk); #1;
        chk("done_pulse_end", done, 0);
        chk("busy_idle", busy, 0);
        chk("count_hold", count, v.exp_n);
    endtask

    initial begin
        int hs;
        bit seen;
        tbl[0] = '{0, 0, 2, 0, 0, 1, 0, 6, 4};
        tbl[1] = '{5, 5, 6, 7, 5, 6, 1, 6, 3};
        tbl[2] = '{2047, 2047, 2047, 2047, 2047, 2047, 0, 1, 1};
        tbl[3] = '{2046, 0, 2047, 0, 2047, 0, 0, 2, 2};
        tbl[4] = '{0, 0, 4, 0, 0, 4, 0, 25, 15};
        tbl[5] = '{0, 0, 2, 0, 0, 1, 2, 6, 4};
        tbl[6] = '{0, 0, 3, 0, 0, 2, 0, 12, 7};

        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_px", px, 0);
        chk("rst_py", py, 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 6; i++) run_scan(tbl[i]);

        // Reset after the third handshake of a 12-point box.
        drive_vtx(tbl[6]);
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        out_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 50 && hs < 3; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) hs++;
            @(posedge clk);
        end
        chk("hs_before_rst", hs, 3);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_count", count, 0);
        out_ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        run_scan(tbl[6]);

        // Held start: a new scan begins on the first IDLE cycle after done.
        drive_vtx(tbl[0]);
        start = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("held_done", seen, 1);
        chk("held_count", count, 6);
        @(posedge clk); #1;
        chk("held_idle", busy, 0);
        @(posedge clk); #1;
        chk("held_rebusy", busy, 1);
        chk("held_recount", count, 0);
        @(posedge clk); #1;
        chk("held_revalid", out_valid, 1);
        chk("held_re_x", px, 0);
        chk("held_re_y", py, 0);
        start = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #3 rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
